// File: rtl/voice_allocator.sv
// Polyphony allocator: key edges -> note_on/note_off events over a shared voice pool, stealing round-robin when full.
// Latency: key sampled at edge t -> outputs at edge t+2; one event serviced per cycle, no backpressure (edges queue as pending bits).
module voice_allocator #(
  parameter int NUM_KEYS       = 8,
  parameter int NUM_VOICES     = 4,
  parameter int KEY_W          = 3,
  parameter int VOICE_W        = 2,
  parameter int RELEASE_CYCLES = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_KEYS-1:0]         key_in,
  output logic [NUM_VOICES-1:0]       voice_gate,
  output logic [NUM_VOICES-1:0]       voice_busy,
  output logic [NUM_VOICES*KEY_W-1:0] voice_key,
  output logic                        note_on,
  output logic                        note_off,
  output logic                        stolen,
  output logic [VOICE_W-1:0]          event_voice
);

  localparam int CNT_W = $clog2(RELEASE_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, HELD, RELEASING} vstate_t;

  logic [NUM_KEYS-1:0] key_q, press_pend, rel_pend;
  vstate_t             state [NUM_VOICES];
  logic [KEY_W-1:0]    vkey  [NUM_VOICES];
  logic [CNT_W-1:0]    cnt   [NUM_VOICES];
  logic [VOICE_W-1:0]  steal_ptr;
  logic                on_r, off_r, stolen_r;
  logic [VOICE_W-1:0]  ev_r;

  logic [NUM_KEYS-1:0] rise, fall, cancel, rel_cand, press_cand, rel_clr, press_clr;
  logic                rel_any, press_any, match_any, idle_any, relg_any;
  logic [KEY_W-1:0]    rel_k, press_k;
  logic [VOICE_W-1:0]  match_v, idle_v, relg_v, chosen_v;
  logic                do_rel, do_press, do_steal;

  assign rise       = key_in & ~key_q;
  assign fall       = ~key_in & key_q;
  // A press released before it was serviced vanishes together with its release.
  assign cancel     = fall & press_pend;
  assign rel_cand   = rel_pend & ~cancel;
  assign press_cand = press_pend & ~cancel;

  always_comb begin
    rel_any   = 1'b0;
    rel_k     = '0;
    press_any = 1'b0;
    press_k   = '0;
    for (int k = NUM_KEYS - 1; k >= 0; k--) begin
      if (rel_cand[k]) begin
        rel_any = 1'b1;
        rel_k   = KEY_W'(k);
      end
      if (press_cand[k]) begin
        press_any = 1'b1;
        press_k   = KEY_W'(k);
      end
    end
    match_any = 1'b0;
    match_v   = '0;
    idle_any  = 1'b0;
    idle_v    = '0;
    relg_any  = 1'b0;
    relg_v    = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (state[v] == HELD && vkey[v] == rel_k) begin
        match_any = 1'b1;
        match_v   = VOICE_W'(v);
      end
      if (state[v] == IDLE) begin
        idle_any = 1'b1;
        idle_v   = VOICE_W'(v);
      end
      if (state[v] == RELEASING) begin
        relg_any = 1'b1;
        relg_v   = VOICE_W'(v);
      end
    end
  end

  assign do_rel    = rel_any;
  assign do_press  = press_any & ~rel_any;
  assign do_steal  = do_press & ~idle_any & ~relg_any;
  assign chosen_v  = idle_any ? idle_v : (relg_any ? relg_v : steal_ptr);
  assign rel_clr   = do_rel   ? (NUM_KEYS'(1) << rel_k)   : '0;
  assign press_clr = do_press ? (NUM_KEYS'(1) << press_k) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      key_q      <= '0;
      press_pend <= '0;
      rel_pend   <= '0;
      steal_ptr  <= '0;
      on_r       <= 1'b0;
      off_r      <= 1'b0;
      stolen_r   <= 1'b0;
      ev_r       <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        state[v] <= IDLE;
        vkey[v]  <= '0;
        cnt[v]   <= '0;
      end
    end else begin
      key_q      <= key_in;
      press_pend <= (press_pend | rise) & ~cancel & ~press_clr;
      rel_pend   <= (rel_pend | fall) & ~cancel & ~rel_clr;
      on_r       <= 1'b0;
      off_r      <= 1'b0;
      stolen_r   <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (state[v] == RELEASING) begin
          cnt[v] <= cnt[v] - CNT_W'(1);
          if (cnt[v] == CNT_W'(1)) state[v] <= IDLE;
        end
      end
      // Assignment below overrides the expiry above when the same voice is picked.
      if (do_rel && match_any) begin
        state[match_v] <= RELEASING;
        cnt[match_v]   <= CNT_W'(RELEASE_CYCLES);
        off_r          <= 1'b1;
        ev_r           <= match_v;
      end
      if (do_press) begin
        state[chosen_v] <= HELD;
        vkey[chosen_v]  <= press_k;
        cnt[chosen_v]   <= '0;
        on_r            <= 1'b1;
        stolen_r        <= do_steal;
        ev_r            <= chosen_v;
        if (do_steal)
          steal_ptr <= (steal_ptr == VOICE_W'(NUM_VOICES - 1)) ? '0 : steal_ptr + VOICE_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      voice_gate  <= '0;
      voice_busy  <= '0;
      voice_key   <= '0;
      note_on     <= 1'b0;
      note_off    <= 1'b0;
      stolen      <= 1'b0;
      event_voice <= '0;
    end else begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        voice_gate[v]                <= (state[v] == HELD);
        voice_busy[v]                <= (state[v] != IDLE);
        voice_key[v*KEY_W +: KEY_W]  <= vkey[v];
      end
      note_on     <= on_r;
      note_off    <= off_r;
      stolen      <= stolen_r;
      event_voice <= ev_r;
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: directed scenarios plus random key traffic against a cycle-level reference model.
module tb_voice_allocator;
  localparam int NK = 8, NV = 4, KW = 3, VW = 2, RC = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [NK-1:0]   key_in;
  logic [NV-1:0]   voice_gate, voice_busy;
  logic [NV*KW-1:0] voice_key;
  logic            note_on, note_off, stolen;
  logic [VW-1:0]   event_voice;

  int cmp_cnt = 0;
  int err_cnt = 0;

  voice_allocator #(.NUM_KEYS(NK), .NUM_VOICES(NV), .KEY_W(KW), .VOICE_W(VW), .RELEASE_CYCLES(RC)) dut (
    .clk(clk), .reset(reset), .key_in(key_in),
    .voice_gate(voice_gate), .voice_busy(voice_busy), .voice_key(voice_key),
    .note_on(note_on), .note_off(note_off), .stolen(stolen), .event_voice(event_voice)
  );

  always #5 clk = ~clk;

  // Reference model: voice states 0=idle 1=held 2=releasing; exp_* are what the outputs show after each edge.
  int m_st[NV], m_vk[NV], m_cnt[NV];
  int m_ptr, m_ev;
  bit m_kq[NK], m_pp[NK], m_rp[NK];
  bit m_on, m_off, m_stl;
  logic [NV-1:0]    exp_gate, exp_busy;
  logic [NV*KW-1:0] exp_key;
  logic             exp_on, exp_off, exp_st;
  logic [VW-1:0]    exp_ev;

  always @(posedge clk) begin
    int rk, pk, mv, cv;
    bit steal_now;
    bit canc[NK];
    if (reset) begin
      for (int v = 0; v < NV; v++) begin m_st[v] = 0; m_vk[v] = 0; m_cnt[v] = 0; end
      for (int k = 0; k < NK; k++) begin m_kq[k] = 0; m_pp[k] = 0; m_rp[k] = 0; end
      m_ptr = 0; m_ev = 0; m_on = 0; m_off = 0; m_stl = 0;
      exp_gate = '0; exp_busy = '0; exp_key = '0;
      exp_on = 0; exp_off = 0; exp_st = 0; exp_ev = '0;
    end else begin
      for (int v = 0; v < NV; v++) begin
        exp_gate[v] = (m_st[v] == 1);
        exp_busy[v] = (m_st[v] != 0);
        exp_key[v*KW +: KW] = KW'(m_vk[v]);
      end
      exp_on = m_on; exp_off = m_off; exp_st = m_stl; exp_ev = VW'(m_ev);
      rk = -1; pk = -1;
      for (int k = NK - 1; k >= 0; k--) begin
        canc[k] = m_pp[k] && m_kq[k] && !key_in[k];
        if (m_rp[k] && !canc[k]) rk = k;
        if (m_pp[k] && !canc[k]) pk = k;
      end
      mv = -1; cv = -1; steal_now = 0;
      if (rk >= 0) begin
        for (int v = NV - 1; v >= 0; v--) if (m_st[v] == 1 && m_vk[v] == rk) mv = v;
      end else if (pk >= 0) begin
        for (int v = NV - 1; v >= 0; v--) if (m_st[v] == 0) cv = v;
        if (cv < 0) for (int v = NV - 1; v >= 0; v--) if (m_st[v] == 2) cv = v;
        if (cv < 0) begin cv = m_ptr; steal_now = 1; m_ptr = (m_ptr + 1) % NV; end
      end
      for (int k = 0; k < NK; k++) begin
        if (canc[k]) begin m_pp[k] = 0; m_rp[k] = 0; end
        else begin
          if (key_in[k] && !m_kq[k]) m_pp[k] = 1;
          if (!key_in[k] && m_kq[k]) m_rp[k] = 1;
        end
        m_kq[k] = key_in[k];
      end
      if (rk >= 0) m_rp[rk] = 0; else if (pk >= 0) m_pp[pk] = 0;
      m_on = 0; m_off = 0; m_stl = 0;
      for (int v = 0; v < NV; v++) if (m_st[v] == 2) begin
        m_cnt[v]--;
        if (m_cnt[v] == 0) m_st[v] = 0;
      end
      if (mv >= 0) begin m_st[mv] = 2; m_cnt[mv] = RC; m_off = 1; m_ev = mv; end
      if (cv >= 0) begin m_st[cv] = 1; m_vk[cv] = pk; m_cnt[cv] = 0; m_on = 1; m_stl = steal_now; m_ev = cv; end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset;
    reset = 1'b1; key_in = '0;
    cyc(2);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; key_in = '0;
    cyc(2);
    cmp_cnt++;
    if ({voice_gate, voice_busy, voice_key, note_on, note_off, stolen, event_voice} !== '0) begin
      err_cnt++;
      $display("FAIL reset_outputs: got gate=%b busy=%b key=%h on=%b off=%b st=%b ev=%0d, want all 0",
               voice_gate, voice_busy, voice_key, note_on, note_off, stolen, event_voice);
    end
    reset = 1'b0;
    cyc(3);
    cmp_cnt++;
    if ({voice_gate, voice_busy, note_on, note_off, stolen} !== '0) begin
      err_cnt++;
      $display("FAIL idle_after_reset: got gate=%b busy=%b on=%b off=%b st=%b, want 0", voice_gate, voice_busy, note_on, note_off, stolen);
    end
  endtask

  task automatic test_press;
    key_in = 8'h01;
    cyc(2);
    cmp_cnt++;
    if (note_on !== 1'b0) begin err_cnt++; $display("FAIL press_early: note_on=%b want 0 one edge before latency", note_on); end
    cyc(1);
    cmp_cnt++;
    if ({note_on, stolen, event_voice, voice_gate, voice_busy, voice_key[KW-1:0]} !== {1'b1, 1'b0, 2'd0, 4'b0001, 4'b0001, 3'd0}) begin
      err_cnt++;
      $display("FAIL press_event: on=%b st=%b ev=%0d gate=%b busy=%b key0=%0d want 1 0 0 0001 0001 0",
               note_on, stolen, event_voice, voice_gate, voice_busy, voice_key[KW-1:0]);
    end
    cyc(1);
    cmp_cnt++;
    if (note_on !== 1'b0) begin err_cnt++; $display("FAIL press_pulse_width: note_on=%b want 0", note_on); end
  endtask

  task automatic test_release;
    int n;
    key_in = 8'h00;
    cyc(3);
    cmp_cnt++;
    if ({note_off, note_on, event_voice, voice_gate, voice_busy} !== {1'b1, 1'b0, 2'd0, 4'b0000, 4'b0001}) begin
      err_cnt++;
      $display("FAIL release_event: off=%b on=%b ev=%0d gate=%b busy=%b want 1 0 0 0000 0001",
               note_off, note_on, event_voice, voice_gate, voice_busy);
    end
    n = 1;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      if (voice_busy[0]) n++; else break;
    end
    cmp_cnt++;
    if (n != RC) begin err_cnt++; $display("FAIL release_busy_len: busy held %0d cycles, want %0d", n, RC); end
  endtask

  task automatic test_two_keys;
    key_in = 8'b0010_1000;
    cyc(3);
    cmp_cnt++;
    if ({note_on, event_voice, voice_key[2:0]} !== {1'b1, 2'd0, 3'd3}) begin
      err_cnt++;
      $display("FAIL two_keys_first: on=%b ev=%0d key0=%0d want 1 0 3", note_on, event_voice, voice_key[2:0]);
    end
    cyc(1);
    cmp_cnt++;
    if ({note_on, event_voice, voice_key[5:3], voice_gate} !== {1'b1, 2'd1, 3'd5, 4'b0011}) begin
      err_cnt++;
      $display("FAIL two_keys_second: on=%b ev=%0d key1=%0d gate=%b want 1 1 5 0011", note_on, event_voice, voice_key[5:3], voice_gate);
    end
  endtask

  task automatic test_steal;
    int offs;
    do_reset;
    key_in = 8'h0F;
    cyc(6);
    cmp_cnt++;
    if ({voice_gate, voice_key} !== {4'hF, 3'd3, 3'd2, 3'd1, 3'd0}) begin
      err_cnt++;
      $display("FAIL steal_fill: gate=%b key=%h want 1111 %h", voice_gate, voice_key, {3'd3, 3'd2, 3'd1, 3'd0});
    end
    key_in = 8'h1F;
    cyc(3);
    cmp_cnt++;
    if ({note_on, stolen, event_voice, voice_key[2:0]} !== {1'b1, 1'b1, 2'd0, 3'd4}) begin
      err_cnt++;
      $display("FAIL steal_first: on=%b st=%b ev=%0d key0=%0d want 1 1 0 4", note_on, stolen, event_voice, voice_key[2:0]);
    end
    key_in = 8'h3F;
    cyc(3);
    cmp_cnt++;
    if ({note_on, stolen, event_voice, voice_key[5:3]} !== {1'b1, 1'b1, 2'd1, 3'd5}) begin
      err_cnt++;
      $display("FAIL steal_second: on=%b st=%b ev=%0d key1=%0d want 1 1 1 5", note_on, stolen, event_voice, voice_key[5:3]);
    end
    key_in = 8'h3E;
    offs = 0;
    for (int i = 0; i < 8; i++) begin cyc(1); if (note_off) offs++; end
    cmp_cnt++;
    if (offs != 0 || voice_gate !== 4'hF) begin
      err_cnt++;
      $display("FAIL stolen_release_silent: note_off count=%0d gate=%b want 0 1111", offs, voice_gate);
    end
  endtask

  task automatic test_cancel;
    int ons, offs;
    logic [VW-1:0] off_ev;
    do_reset;
    key_in = 8'h02;
    cyc(4);
    key_in = 8'h04;
    cyc(1);
    key_in = 8'h00;
    ons = 0; offs = 0; off_ev = '1;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      if (note_on) ons++;
      if (note_off) begin offs++; off_ev = event_voice; end
    end
    cmp_cnt++;
    if (ons != 0 || offs != 1 || off_ev !== 2'd0) begin
      err_cnt++;
      $display("FAIL cancel_glitch: note_on count=%0d note_off count=%0d off_voice=%0d want 0 1 0", ons, offs, off_ev);
    end
  endtask

  task automatic test_reset_mid;
    do_reset;
    key_in = 8'h07;
    cyc(6);
    reset = 1'b1;
    cyc(1);
    cmp_cnt++;
    if ({voice_gate, voice_busy, note_on, note_off, stolen} !== '0) begin
      err_cnt++;
      $display("FAIL reset_mid: gate=%b busy=%b on=%b off=%b st=%b want all 0", voice_gate, voice_busy, note_on, note_off, stolen);
    end
    reset = 1'b0;
    cyc(2);
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      cmp_cnt++;
      if ({note_on, event_voice} !== {1'b1, VW'(i)}) begin
        err_cnt++;
        $display("FAIL repress_%0d: on=%b ev=%0d want 1 %0d", i, note_on, event_voice, i);
      end
    end
  endtask

  task automatic test_random;
    logic [24:0] obs, exp_v;
    int local_err;
    local_err = 0;
    do_reset;
    for (int i = 0; i < 4000 && local_err < 40; i++) begin
      cyc(1);
      obs   = {voice_gate, voice_busy, voice_key, note_on, note_off, stolen, event_voice};
      exp_v = {exp_gate, exp_busy, exp_key, exp_on, exp_off, exp_st, exp_ev};
      cmp_cnt++;
      if (obs !== exp_v || (note_on && note_off)) begin
        err_cnt++; local_err++;
        $display("FAIL random_cycle_%0d: got %h want %h (gate,busy,key,on,off,st,ev)", i, obs, exp_v);
      end
      for (int k = 0; k < NK; k++)
        if ($urandom_range(0, 11) == 0) key_in[k] = ~key_in[k];
      reset = ($urandom_range(0, 399) == 0);
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    key_in = '0;
    test_reset;
    test_press;
    test_release;
    test_two_keys;
    test_steal;
    test_cancel;
    test_reset_mid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
Polyphony controller for the synth. It watches the per-key level inputs from the keyboard front end and turns press/release edges into note-on and note-off events. It shares a fixed pool of oscillator voices among the keys, steals a voice when the pool is full, and drives per-voice gate and key-index outputs. It sits between the key scanning/debounce logic and the voice oscillator/envelope datapath.

Parameters:
NUM_KEYS, 8, number of key inputs.
NUM_VOICES, 4, number of oscillator voices shared.
KEY_W, 3, width of a key index; must be at least clog2(NUM_KEYS).
VOICE_W, 2, width of a voice index; must be at least clog2(NUM_VOICES).
RELEASE_CYCLES, 4, cycles a voice stays in RELEASING after its gate drops; must be at least 1.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
key_in  input  NUM_KEYS  debounced key levels; 1 = held
voice_gate  output  NUM_VOICES  1 while the voice is HELD
voice_busy  output  NUM_VOICES  1 while the voice is HELD or RELEASING
voice_key  output  NUM_VOICES*KEY_W  key index per voice; voice v occupies bits [v*KEY_W +: KEY_W]
note_on  output  1  one-cycle pulse when a key is assigned to a voice
note_off  output  1  one-cycle pulse when a HELD voice is released
stolen  output  1  one-cycle pulse coinciding with note_on when a HELD voice was stolen
event_voice  output  VOICE_W  voice index for the current note_on/note_off; holds its last value otherwise

Behaviour:
- Reset: key_q=0, all pending bits 0, every voice IDLE, voice_key=0, release counters=0, steal_ptr=0. All outputs are 0.
- A key held through reset is seen as a rising edge after reset and produces a press.
- Edge capture: key_q <= key_in every cycle. A rising edge (key_in & ~key_q) sets press_pend[k]. A falling edge sets rel_pend[k].
- If a falling edge arrives while press_pend[k] is still set, clear both bits. The press is dropped and no events are emitted.
- Service: at most one pending event per cycle. Any release beats any press. Among releases or among presses, the lowest key index wins. The serviced pending bit is cleared in the same cycle.
- Edge capture and service are evaluated together each cycle. An edge captured in cycle t is serviceable from cycle t+1.
- Latency: an isolated press is sampled high at edge t. note_on, voice_gate and voice_key then update at edge t+2. Release follows the same timing.
- Voice FSM, per voice:
  - IDLE -> HELD on assignment.
  - HELD -> RELEASING on release service; the counter loads RELEASE_CYCLES.
  - RELEASING decrements the counter each cycle and goes to IDLE when it reaches 0 on that edge.
  - RELEASING -> HELD when the voice is reassigned.
  - HELD -> HELD when the voice is stolen; voice_key is overwritten.
- Release service for key k: find the HELD voice with voice_key==k. It goes to RELEASING, voice_gate=0, note_off pulses, and event_voice = that voice.
- If no HELD voice matches (the voice was stolen), clear the pending bit silently with no pulse.
- Press service, voice choice in order:
  1. The lowest-index IDLE voice.
  2. Otherwise, the lowest-index RELEASING voice.
  3. Otherwise, the voice at steal_ptr. Pulse stolen and set steal_ptr = (steal_ptr+1) mod NUM_VOICES. Wrap-around is explicit for non-power-of-2 NUM_VOICES.
- On any press service: voice_key=k, state HELD, gate=1, note_on pulses, event_voice = chosen voice.
- Pulses: note_on, note_off and stolen are each high for exactly one cycle per event.
- Exclusivity: note_on and note_off are never high in the same cycle.
- A RELEASING voice whose counter expires in the same cycle it is chosen by press service goes to HELD, not IDLE.
- Reset mid-operation: all voices are forced IDLE immediately. No note_off is emitted.

Test Plan:
1. Reset, then key_in=0000_0001 at edge 2 -> note_on high at edge 4 only; event_voice=0, voice_gate=0001, voice_key[0]=0.
2. Release key 0 -> note_off one cycle with event_voice=0, gate=0000. voice_busy[0] stays 1 for 4 cycles, then drops to 0.
3. Keys 3 and 5 rise in the same cycle -> note_on on two consecutive cycles: key 3 to voice 0, then key 5 to voice 1.
4. Keys 0–3 held, then key 4 pressed -> note_on and stolen together, event_voice=0, voice_key[0]=4. Key 5 pressed next steals voice 1. Later release of key 0 produces no note_off.
5. Key 2 rises and falls within one cycle, while key 1 release is pending -> release of key 1 serviced first. No note_on ever occurs for key 2.
6. Reset asserted while 3 voices are HELD -> next cycle voice_gate=0, voice_busy=0, all pulses 0. Keys still held are re-pressed: 3 note_ons on consecutive cycles.
